fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the synchronous FIFO. It pulls one word at a time through the FIFO read port and serialises each word as an asynchronous UART frame on a single line. The frame is a start bit, DATA_WIDTH data bits LSB first, an optional even-parity bit and STOP_BITS stop bits. It sits between the FIFO's data_out/empty/r_en port and the chip-level serial pin.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  reset, synchronous, active-high
tx_en  input  1  permits starting a new frame; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after the read
fifo_r_en  output  1  FIFO read enable; single-cycle pulse
tx  output  1  serial line; idle high
busy  output  1  high whenever the state is not IDLE
frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset values: tx=1, busy=0, fifo_r_en=0, frame_done=0, state=IDLE. Bit counter, baud counter and shift register clear to 0.
- States: IDLE, READ, LATCH, START, DATA, PARITY, STOP.
- IDLE -> READ: when tx_en=1 and fifo_empty=0. Otherwise stay in IDLE.
- READ: lasts exactly 1 cycle. fifo_r_en=1 in this cycle only (Moore output). Next state is LATCH.
- LATCH: lasts 1 cycle. On its closing edge, fifo_data is captured into the shift register and the parity bit is computed as XOR of all data bits. Next state is START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0]. Shift right every CLKS_PER_BIT cycles. Leave after DATA_WIDTH bits.
- PARITY: present only if PARITY_EN=1. tx=parity for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done=1 in the final cycle. Next state is IDLE.
- Latency: if IDLE sees the read condition at edge N, then READ covers cycle N..N+1, LATCH covers N+1..N+2, and tx falls at edge N+2.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles from the tx falling edge to the end of the last stop bit.
- Back-to-back frames: the FSM always returns to IDLE. Minimum gap between the end of one stop bit and the next start bit is 3 cycles (IDLE, READ, LATCH), with tx=1 throughout.
- The baud counter runs 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It clears on every state change.
- The bit counter width is $clog2(DATA_WIDTH+1).
- fifo_r_en is never asserted while fifo_empty=1. Exactly one fifo_r_en pulse occurs per transmitted frame.
- tx_en deasserted mid-frame does not abort the frame. It only blocks the next IDLE -> READ transition.
- fifo_empty changes after READ are ignored until the FSM is back in IDLE.
- Reset mid-frame: at the reset edge, tx=1, busy=0 and state=IDLE. The partial frame is discarded and the FIFO word already popped is lost. No fifo_r_en is issued during reset.
- tx, busy and frame_done are registered (glitch-free). fifo_r_en is decoded from the state register.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; FIFO holds 0xA5; tx_en=1.
   -> fifo_r_en is high for exactly 1 cycle.
   -> tx falls 2 cycles after the IDLE sample.
   -> tx sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total).
   -> frame_done pulses once in the 40th cycle.
2. PARITY_EN=1; words 0xA5 then 0x07.
   -> parity bit is 0 for 0xA5 and 1 for 0x07.
   -> each frame is 44 cycles.
   -> the two frames are separated by exactly 3 tx=1 cycles.
3. STOP_BITS=2; FIFO empty; tx_en=1 for 50 cycles, then 0x3C is written.
   -> no fifo_r_en and tx=1 while the FIFO is empty.
   -> the frame then sends an 8-cycle stop period.
4. tx_en dropped to 0 in the middle of the data bits of 0x55, with a second word queued.
   -> the current frame completes intact.
   -> no further fifo_r_en until tx_en returns to 1.
5. rst asserted during the 3rd data bit.
   -> at the next edge tx=1, busy=0, frame_done=0.
   -> after release with the FIFO empty, the line stays idle.
6. FIFO filled with 8 words 0x00..0x07.
   -> exactly 8 fifo_r_en pulses and 8 frame_done pulses.
   -> bytes appear in order on tx.
   -> busy=0 after the last frame.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a synchronous FIFO one word at a time and sends each
// word as a UART frame: start bit, DATA_WIDTH data bits LSB first, optional
// even-parity bit, STOP_BITS stop bits. tx, busy and frame_done are registered
// from next-state values so they line up exactly with the state they describe.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t                  state_r, state_s;
  logic [BAUD_W-1:0]       baud_r, baud_s;
  logic [BIT_W-1:0]        bit_r, bit_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s;
  logic                    parity_r, parity_s;
  logic                    tx_r, tx_s;
  logic                    busy_r, busy_s;
  logic                    frame_done_r, frame_done_s;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  // Next-state, counter and shift-register logic for the frame sequencer.
  always_comb begin
    state_s  = state_r;
    baud_s   = baud_r;
    bit_s    = bit_r;
    shift_s  = shift_r;
    parity_s = parity_r;
    case (state_r)
      IDLE: begin
        baud_s = '0;
        bit_s  = '0;
        if (tx_en && !fifo_empty) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        baud_s  = '0;
        state_s = LATCH;
      end
      LATCH: begin
        baud_s   = '0;
        bit_s    = '0;
        shift_s  = fifo_data;
        parity_s = even_parity(fifo_data);
        state_s  = START;
      end
      START: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = DATA;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s   = '0;
            state_s = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      PARITY: begin
        if (baud_r == BAUD_LAST) begin
          baud_s  = '0;
          state_s = STOP;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == STOP_LAST) begin
            bit_s   = '0;
            state_s = IDLE;
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = '0;
        bit_s   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_s;
      default: tx_s = 1'b1;
    endcase
    busy_s       = (state_s != IDLE);
    frame_done_s = (state_s == STOP) && (baud_s == BAUD_LAST) && (bit_s == STOP_LAST);
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      baud_r       <= '0;
      bit_r        <= '0;
      shift_r      <= '0;
      parity_r     <= 1'b0;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      bit_r        <= bit_s;
      shift_r      <= shift_s;
      parity_r     <= parity_s;
      tx_r         <= tx_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
    end
  end

  // Read strobe is a Moore decode of READ so it lasts exactly one cycle.
  assign fifo_r_en  = (state_r == READ);
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (8N1, 8E1, 8N2 at 4 clk/bit) run the
// same directed sequence against a FIFO model; a per-instance frame decoder
// pops expected words from a scoreboard and compares whole frames.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int N   = 3;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty [N];
  logic [7:0] fifo_data  [N];
  logic       fifo_r_en  [N];
  logic       tx         [N];
  logic       busy       [N];
  logic       frame_done [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    fifo_uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 1) ? 1 : 0),
      .STOP_BITS   ((g == 2) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .fifo_empty(fifo_empty[g]),
      .fifo_data (fifo_data[g]),
      .fifo_r_en (fifo_r_en[g]),
      .tx        (tx[g]),
      .busy      (busy[g]),
      .frame_done(frame_done[g])
    );
  end

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] fifo_q [N][$];
  logic [7:0] exp_q  [N][$];

  bit         mon_act  [N];
  int         mon_cnt  [N];
  logic [15:0] mon_bits [N];
  bit         mon_glitch [N];
  int         gap_cnt  [N];
  bit         gap_on   [N];
  int         last_gap [N];
  int         ren_cnt  [N];
  int         done_cnt [N];
  int         ren_cyc  [N];
  bit         prev_ren [N];
  logic [7:0] pend     [N];
  bit         pend_v   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return (10 + ((i == 1) ? 1 : 0) + ((i == 2) ? 1 : 0)) * CPB;
  endfunction

  function automatic logic [15:0] exp_frame(input int i, input logic [7:0] d);
    logic [15:0] f;
    f      = 16'hFFFF;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (i == 1) f[9] = ^d;
    return f;
  endfunction

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < N; i++) begin
      fifo_q[i].push_back(w);
      exp_q[i].push_back(w);
      fifo_empty[i] = 1'b0;
    end
  endtask

  // Per-cycle FIFO model and frame decoder, run at each falling edge.
  task automatic monitor();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mon_act[i] = 1'b0;
        gap_on[i]  = 1'b0;
        prev_ren[i] = 1'b0;
        pend_v[i]  = 1'b0;
      end else begin
        if (pend_v[i]) begin
          fifo_data[i] = pend[i];
          pend_v[i]    = 1'b0;
        end
        if (fifo_r_en[i] === 1'b1) begin
          chk($sformatf("ren_nonempty[%0d]", i), fifo_q[i].size() > 0, 1);
          chk($sformatf("ren_single_cycle[%0d]", i), prev_ren[i], 0);
          ren_cnt[i]++;
          ren_cyc[i] = cyc;
          if (fifo_q[i].size() > 0) begin
            pend[i]   = fifo_q[i].pop_front();
            pend_v[i] = 1'b1;
          end
        end
        prev_ren[i]   = (fifo_r_en[i] === 1'b1);
        fifo_empty[i] = (fifo_q[i].size() == 0);
        if (frame_done[i] === 1'b1) done_cnt[i]++;

        if (!mon_act[i]) begin
          if (tx[i] === 1'b0) begin
            mon_act[i]    = 1'b1;
            mon_cnt[i]    = 0;
            mon_bits[i]   = 16'hFFFF;
            mon_glitch[i] = 1'b0;
            chk($sformatf("start_latency[%0d]", i), cyc - ren_cyc[i], 2);
            if (gap_on[i]) last_gap[i] = gap_cnt[i];
            gap_on[i] = 1'b0;
          end else begin
            if (gap_on[i]) gap_cnt[i]++;
            chk($sformatf("frame_done_idle[%0d]", i), frame_done[i], 0);
          end
        end
        if (mon_act[i]) begin
          if (mon_cnt[i] % CPB == 0) mon_bits[i][mon_cnt[i] / CPB] = tx[i];
          else if (tx[i] !== mon_bits[i][mon_cnt[i] / CPB]) mon_glitch[i] = 1'b1;
          chk($sformatf("frame_done[%0d]@%0d", i, mon_cnt[i]), frame_done[i],
              (mon_cnt[i] == frame_len(i) - 1) ? 1 : 0);
          chk($sformatf("busy_in_frame[%0d]", i), busy[i], 1);
          if (mon_cnt[i] == frame_len(i) - 1) begin
            mon_act[i] = 1'b0;
            gap_on[i]  = 1'b1;
            gap_cnt[i] = 0;
            chk($sformatf("frame_expected[%0d]", i), exp_q[i].size() > 0, 1);
            if (exp_q[i].size() > 0) begin
              logic [7:0] e;
              e = exp_q[i].pop_front();
              chk($sformatf("frame_bits[%0d]", i), mon_bits[i], exp_frame(i, e));
            end
            chk($sformatf("bit_stable[%0d]", i), mon_glitch[i], 0);
          end else begin
            mon_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  // Wait until every scoreboard holds 'left' words and every instance is idle.
  task automatic wait_idle(input string tag, input int left, input int budget);
    int  n;
    bit  pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < budget) begin
      tick();
      n++;
      pending = 1'b0;
      for (int i = 0; i < N; i++)
        if (exp_q[i].size() != left || busy[i] !== 1'b0) pending = 1'b1;
    end
    chk(tag, pending, 0);
  endtask

  task automatic wait_cnt(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (!(mon_act[0] && mon_cnt[0] == target) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, n < budget, 1);
  endtask

  // Linear directed sequence.
  initial begin
    int ren0 [N];
    int done0 [N];
    int bad [N];

    rst   = 1'b1;
    tx_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = 1'b1;
      fifo_data[i]  = 8'h00;
      ren_cyc[i]    = -100;
      last_gap[i]   = -1;
    end
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_tx[%0d]", i), tx[i], 1);
      chk($sformatf("reset_busy[%0d]", i), busy[i], 0);
      chk($sformatf("reset_ren[%0d]", i), fifo_r_en[i], 0);
      chk($sformatf("reset_done[%0d]", i), frame_done[i], 0);
    end
    rst = 1'b0;
    tick();

    // 1: single word 0xA5
    push_word(8'hA5);
    tx_en = 1'b1;
    wait_idle("t1_timeout", 0, 200);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t1_ren_count[%0d]", i), ren_cnt[i], 1);
      chk($sformatf("t1_done_count[%0d]", i), done_cnt[i], 1);
    end

    // 2: two queued words, back to back
    push_word(8'hA5);
    push_word(8'h07);
    wait_idle("t2_timeout", 0, 300);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t2_gap[%0d]", i), last_gap[i], 3);
      chk($sformatf("t2_done_count[%0d]", i), done_cnt[i], 3);
    end

    // 3: empty FIFO with tx_en high, then a late write
    for (int i = 0; i < N; i++) begin
      ren0[i] = ren_cnt[i];
      bad[i]  = 0;
    end
    repeat (50) begin
      tick();
      for (int i = 0; i < N; i++)
        if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || fifo_r_en[i] !== 1'b0) bad[i]++;
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t3_idle_line[%0d]", i), bad[i], 0);
      chk($sformatf("t3_no_ren[%0d]", i), ren_cnt[i], ren0[i]);
    end
    push_word(8'h3C);
    wait_idle("t3_timeout", 0, 200);

    // 4: tx_en dropped mid-frame with a second word queued
    push_word(8'h55);
    push_word(8'h96);
    wait_cnt("t4_reach_data", 18, 100);
    tx_en = 1'b0;
    wait_idle("t4_first_frame", 1, 200);
    for (int i = 0; i < N; i++) ren0[i] = ren_cnt[i];
    repeat (30) tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t4_held_ren[%0d]", i), ren_cnt[i], ren0[i]);
      chk($sformatf("t4_held_busy[%0d]", i), busy[i], 0);
    end
    tx_en = 1'b1;
    wait_idle("t4_second_frame", 0, 200);
    for (int i = 0; i < N; i++)
      chk($sformatf("t4_ren_after[%0d]", i), ren_cnt[i], ren0[i] + 1);

    // 5: reset during the third data bit
    push_word(8'h81);
    wait_cnt("t5_reach_bit3", 14, 100);
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t5_rst_tx[%0d]", i), tx[i], 1);
      chk($sformatf("t5_rst_busy[%0d]", i), busy[i], 0);
      chk($sformatf("t5_rst_done[%0d]", i), frame_done[i], 0);
      void'(exp_q[i].pop_front());
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      ren0[i] = ren_cnt[i];
      bad[i]  = 0;
    end
    repeat (30) begin
      tick();
      for (int i = 0; i < N; i++)
        if (tx[i] !== 1'b1 || busy[i] !== 1'b0) bad[i]++;
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t5_idle_after[%0d]", i), bad[i], 0);
      chk($sformatf("t5_no_ren[%0d]", i), ren_cnt[i], ren0[i]);
    end

    // 6: eight words in order
    for (int i = 0; i < N; i++) begin
      ren0[i]  = ren_cnt[i];
      done0[i] = done_cnt[i];
    end
    for (int w = 0; w < 8; w++) push_word(8'(w));
    wait_idle("t6_timeout", 0, 1000);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("t6_ren_count[%0d]", i), ren_cnt[i] - ren0[i], 8);
      chk($sformatf("t6_done_count[%0d]", i), done_cnt[i] - done0[i], 8);
      chk($sformatf("t6_busy_end[%0d]", i), busy[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
